// File: rtl/sd4_mac_pkg.sv
// Shared types and defaults for the SD4 MAC sequencer slice.
package sd4_mac_pkg;

    localparam int SUM_W_DEF = 20;
    localparam int ACC_W_DEF = 32;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Sign-extend the low w bits of v to 64 bits; callers truncate.
    function automatic logic [63:0] sext64(
        input logic [63:0] v,
        input int          w
    );
        logic signed [63:0] t;
        t = $signed(v << (64 - w)) >>> (64 - w);
        return $unsigned(t);
    endfunction

endpackage

// File: rtl/sd4_acc_unit.sv
// Stage register, sign-extending accumulator and sticky overflow.
module sd4_acc_unit
    import sd4_mac_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [SUM_W-1:0] d,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    logic [SUM_W-1:0] stage;
    logic             stage_v;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    logic             ov;

    always_comb begin
        ext = ACC_W'(sext64(64'(stage), SUM_W));
        sum = acc + ext;
        ov  = (acc[ACC_W-1] == ext[ACC_W-1])
           && (sum[ACC_W-1] != acc[ACC_W-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage   <= '0;
            stage_v <= 1'b0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else begin
            stage_v <= ld;
            if (ld)
                stage <= d;
            if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (stage_v) begin
                acc <= sum;
                ovf <= ovf | ov;
            end
        end
    end

endmodule

// File: rtl/sd4_mac_seq.sv
// Dot-product sequencer: counts tree sums in, drains, presents result.
module sd4_mac_seq
    import sd4_mac_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] tree_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len;
    logic             accept;
    logic             fire;
    logic             last;

    always_comb begin
        accept = start && (cfg_len != '0)
              && ((state == IDLE)
               || (state == DONE && out_ready));
        fire   = in_valid && in_ready;
        last   = (cnt == len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = ACCUM;
            ACCUM: if (last) state_nx = DRAIN;
            DRAIN: state_nx = DONE;
            DONE:
                if (out_ready)
                    state_nx = accept ? ACCUM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The cycle after the last transfer is spent adding the staged term.
    always_comb begin
        in_ready  = (state == ACCUM) && !last;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            len <= '0;
        end else if (accept) begin
            cnt <= '0;
            len <= cfg_len;
        end else if (fire) begin
            cnt <= cnt + 1'b1;
        end
    end

    sd4_acc_unit #(
        .SUM_W (SUM_W),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .ld  (fire),
        .d   (tree_sum),
        .acc (out_acc),
        .ovf (out_ovf)
    );

endmodule

// File: tb/tb_sd4_mac_seq.sv
// Directed scoreboard bench for sd4_mac_seq (32-bit and 22-bit builds).
module tb_sd4_mac_seq;

    typedef struct {
        longint a32;
        bit     o32;
        longint a22;
        bit     o22;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [19:0] tree_sum;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf, busy;
    logic [31:0] out_acc;
    logic        in_ready22, out_valid22, out_ovf22, busy22;
    logic [21:0] out_acc22;

    int     n_assert = 0;
    int     n_fail = 0;
    exp_t   q[$];
    longint ma32, ma22;
    bit     mo32, mo22;

    always #5 clk = ~clk;

    sd4_mac_seq dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .tree_sum(tree_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc),
        .out_ovf(out_ovf), .busy(busy)
    );

    sd4_mac_seq #(.ACC_W(22)) dut22 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready22),
        .tree_sum(tree_sum), .out_valid(out_valid22),
        .out_ready(out_ready), .out_acc(out_acc22),
        .out_ovf(out_ovf22), .busy(busy22)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= m / 2)
            r = r - m;
        return r;
    endfunction

    task automatic mclr();
        ma32 = 0; mo32 = 0;
        ma22 = 0; mo22 = 0;
    endtask

    task automatic madd(input longint t);
        longint s;
        s = ma32 + t;
        if (s > 64'sd2147483647 || s < -64'sd2147483648)
            mo32 = 1;
        ma32 = wrapw(s, 32);
        s = ma22 + t;
        if (s > 64'sd2097151 || s < -64'sd2097152)
            mo22 = 1;
        ma22 = wrapw(s, 22);
    endtask

    task automatic push();
        exp_t e;
        e.a32 = ma32; e.o32 = mo32;
        e.a22 = ma22; e.o22 = mo22;
        q.push_back(e);
    endtask

    task automatic cmd(input logic [7:0] len);
        start = 1'b1;
        cfg_len = len;
        cyc();
        start = 1'b0;
        mclr();
    endtask

    task automatic feed(input longint v, input int gap);
        logic [63:0] vv;
        int k;
        vv = v;
        in_valid = 1'b0;
        repeat (gap) cyc();
        in_valid = 1'b1;
        tree_sum = vv[19:0];
        k = 0;
        while (!in_ready && k < 50) begin
            cyc();
            k++;
        end
        check("feed_in_ready", longint'(in_ready), 1);
        if (in_ready)
            madd(v);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!out_valid && k < 1000) begin
            cyc();
            k++;
        end
        check("wait_out_valid", longint'(out_valid), 1);
    endtask

    task automatic collect(input logic st, input logic [7:0] ln);
        exp_t e;
        out_ready = 1'b1;
        start = st;
        cfg_len = ln;
        wait_valid();
        check("out_valid22", longint'(out_valid22), 1);
        check("sb_has_entry", longint'(q.size() > 0), 1);
        e = '{0, 0, 0, 0};
        if (q.size() > 0)
            e = q.pop_front();
        check("out_acc", $signed(out_acc), e.a32);
        check("out_ovf", longint'(out_ovf), longint'(e.o32));
        check("out_acc22", $signed(out_acc22), e.a22);
        check("out_ovf22", longint'(out_ovf22), longint'(e.o22));
        cyc();
        out_ready = 1'b0;
        start = 1'b0;
        if (st)
            mclr();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0;
        cfg_len = '0;
        in_valid = 1'b0;
        tree_sum = '0;
        out_ready = 1'b0;
        mclr();
        repeat (2) cyc();
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_acc", $signed(out_acc), 0);
        check("rst_out_ovf", longint'(out_ovf), 0);
        check("rst_busy", longint'(busy), 0);
        rst = 1'b0;
        cyc();

        // zero-length command is dropped
        start = 1'b1;
        cfg_len = 8'd0;
        cyc();
        start = 1'b0;
        cyc();
        check("len0_busy", longint'(busy), 0);
        check("len0_in_ready", longint'(in_ready), 0);

        // basic run and latency
        cmd(8'd3);
        feed(100, 0);
        feed(-50, 0);
        feed(7, 0);
        push();
        check("lat_t1_valid", longint'(out_valid), 0);
        check("lat_t1_busy", longint'(busy), 1);
        cyc();
        check("lat_t2_valid", longint'(out_valid), 0);
        cyc();
        check("lat_t3_valid", longint'(out_valid), 1);
        check("basic_const", $signed(out_acc), 57);
        collect(1'b0, 8'd0);
        check("basic_busy_fall", longint'(busy), 0);

        // bubbles, extra in_valid refused, output stall
        cmd(8'd4);
        feed(1000, 0);
        feed(2000, 2);
        feed(-3000, 1);
        feed(4, 0);
        push();
        in_valid = 1'b1;
        tree_sum = 20'd99;
        check("extra_in_ready", longint'(in_ready), 0);
        cyc();
        check("extra_in_ready2", longint'(in_ready), 0);
        in_valid = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", longint'(out_valid), 1);
            check("stall_acc", $signed(out_acc), 4);
            cyc();
        end

        // back-to-back restart on the output handshake
        collect(1'b1, 8'd1);
        check("b2b_busy", longint'(busy), 1);
        check("b2b_in_ready", longint'(in_ready), 1);
        feed(-524288, 0);
        push();
        collect(1'b0, 8'd0);
        check("b2b_const", $signed(out_acc), -524288);

        // extremes
        cmd(8'd255);
        repeat (255) feed(-524288, 0);
        push();
        collect(1'b0, 8'd0);
        check("min_const", $signed(out_acc), -133693440);
        cmd(8'd255);
        repeat (255) feed(524287, 0);
        push();
        collect(1'b0, 8'd0);
        check("max_const", $signed(out_acc), 133693185);

        // overflow in the narrow build
        cmd(8'd5);
        repeat (5) feed(524287, 0);
        push();
        collect(1'b0, 8'd0);
        check("ovf22_acc", $signed(out_acc22), -1572869);
        check("ovf22_flag", longint'(out_ovf22), 1);
        check("ovf32_flag", longint'(out_ovf), 0);

        // start during ACCUM is ignored
        cmd(8'd3);
        feed(11, 0);
        start = 1'b1;
        cfg_len = 8'd5;
        cyc();
        start = 1'b0;
        feed(22, 0);
        feed(33, 0);
        push();
        collect(1'b0, 8'd0);
        check("ign_const", $signed(out_acc), 66);

        // reset mid-operation
        cmd(8'd4);
        feed(3, 0);
        feed(4, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_acc", $signed(out_acc), 0);
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_in_ready", longint'(in_ready), 0);
        check("mid_rst_ovf", longint'(out_ovf), 0);
        check("mid_rst_acc22", $signed(out_acc22), 0);
        check("mid_rst_busy22", longint'(busy22), 0);
        check("mid_rst_rdy22", longint'(in_ready22), 0);
        cyc();
        rst = 1'b0;
        repeat (4) begin
            cyc();
            check("post_rst_valid", longint'(out_valid), 0);
        end
        cmd(8'd2);
        feed(5, 0);
        feed(6, 0);
        push();
        collect(1'b0, 8'd0);
        check("post_rst_const", $signed(out_acc), 11);

        check("sb_drained", longint'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sd4_mac_seq.md
Name: sd4_mac_seq

Overview:
- Sequencer and accumulator for the SD4 MAC's combinational partial-product adder tree.
- Accepts a command to perform a dot product of cfg_len terms.
- Takes one 20-bit tree sum per valid/ready handshake, registers it, and accumulates it into a wide signed accumulator.
- Presents the final result on a valid/ready output port. Sits between the tree's signed_sum output and the downstream writeback/activation stage.

Parameters:
- SUM_W, 20, width of the signed adder-tree sum.
- ACC_W, 32, width of the signed accumulator/result; must be >= SUM_W.
- LEN_W, 8, width of the term-count field. Maximum length is 2^LEN_W-1.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command pulse. Sampled only in IDLE, or in DONE on the cycle of the output handshake.
- cfg_len  in  LEN_W  number of terms. Captured with start; 0 means the command is ignored.
- in_valid  in  1  tree_sum is valid.
- in_ready  out  1  sequencer accepts a term.
- tree_sum  in  SUM_W  signed sum from the adder tree.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  signed dot-product result.
- out_ovf  out  1  sticky signed-overflow flag for this result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE. Count, stage register, stage_v, accumulator and ovf are all cleared.
  - Outputs: in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 with cfg_len!=0: latch len, clear cnt/acc/ovf, go to ACCUM.
  - start with cfg_len=0: no effect.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready: stage <= tree_sum, stage_v <= 1, cnt <= cnt+1. Otherwise stage_v <= 0.
  - When the handshake makes cnt==len, go to DRAIN on the next edge.
- DRAIN:
  - One cycle, in_ready=0. The final staged term is added, then go to DONE.
- Accumulate:
  - Every cycle stage_v=1: acc <= acc + sign_extend(stage, ACC_W). Addition wraps modulo 2^ACC_W.
  - ovf <= ovf | (both operands same sign and result sign differs).
- DONE:
  - out_valid=1; out_acc and out_ovf are held stable until out_valid&out_ready.
  - On that handshake: if start=1 and cfg_len!=0, restart directly into ACCUM (cleared acc/ovf). Otherwise go to IDLE.
  - out_acc keeps its last value in IDLE. It is cleared only at the next accepted start or at reset.
- Latency: the last term's handshake occurs at edge t. out_valid rises after edge t+2. Gaps in in_valid only stretch ACCUM.
- start during ACCUM or DRAIN, or in DONE without out_ready: ignored; the command is not queued.
- in_valid while in_ready=0: no transfer, no state change.
- Reset mid-operation: aborts immediately. The partial result is discarded and no out_valid is produced.
- Widths: with default parameters the worst case is 255 x (-2^19) = -133,693,440, which fits in 32 bits, so ovf never sets. The flag exists for reduced ACC_W builds.

Decomposition:
- Shared package sd4_mac_pkg holds:
  - state enum (IDLE/ACCUM/DRAIN/DONE, 2-bit encoding);
  - SUM_W/ACC_W/LEN_W defaults;
  - a sign-extension helper function.
- One natural sub-module: sd4_acc_unit, containing the stage register, the sign-extended adder and the sticky-overflow logic, with clear/enable inputs driven by the FSM.
- FSM and counter stay in sd4_mac_seq.

Test Plan:
- Basic: start, len=3; terms 100, -50, 7 on consecutive cycles; out_ready=1 -> out_valid 2 cycles after the 3rd handshake, out_acc=57, out_ovf=0, busy falls on the next cycle.
- Input bubbles/backpressure: len=4; terms 1000, 2000, -3000, 4 with 0/2/1-cycle in_valid gaps -> out_acc=4. Extra in_valid after the 4th term is not accepted (in_ready=0).
- Output stall + back-to-back: out_ready low 5 cycles -> out_acc stable. Then out_ready=1 with start=1 and len=1, term -524288 -> second result -524288, no IDLE cycle between.
- Extremes: len=255, all terms -524288 -> out_acc=-133,693,440, out_ovf=0. The same run with 524287 -> out_acc=133,693,185.
- Overflow (ACC_W=22): len=5, all terms 524287 -> out_ovf=1, out_acc=-1,572,869 (wrapped).
- Control corners:
  - start with len=0 -> busy stays 0.
  - start during ACCUM -> ignored, result unchanged.
  - rst asserted after 2 of 4 terms -> all outputs 0 immediately, no out_valid. A new len=2 run (5, 6) then gives 11.
